// File: rtl/pif_pwm_capture.sv
// PWM line reader: reports period and on-time between successive active-going
// edges with a one-cycle Valid strobe; a line that stops toggling raises Timeout.
module pif_pwm_capture #(
  parameter int CW          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          PwmIn,
  output logic [CW-1:0] Period,
  output logic [CW-1:0] OnTime,
  output logic          Valid,
  output logic          Timeout,
  output logic          StuckLevel,
  output logic          Busy
);

  localparam logic                   ACT_INV   = (ACTIVE_LOW != 0);
  localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ACT_INV}};
  localparam logic [CW-1:0]          CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0]          CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic {
    SEEK = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The period counter must never wrap; reaching all-ones ends the measurement.
  function automatic logic cnt_saturated(input logic [CW-1:0] cnt);
    return cnt == CNT_MAX;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   act_dly_q, act_dly_d;
  state_e                 state_q, state_d;
  logic [CW-1:0]          per_cnt_q, per_cnt_d;
  logic [CW-1:0]          on_cnt_q, on_cnt_d;
  logic [CW-1:0]          period_q, period_d;
  logic [CW-1:0]          on_time_q, on_time_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   stuck_q, stuck_d;
  logic                   act;
  logic                   rise;

  // Synchronizer and edge detect
  assign act  = sync_q[SYNC_STAGES-1] ^ ACT_INV;
  assign rise = act & ~act_dly_q;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], PwmIn};
    act_dly_d = act;
  end

  // Measurement FSM
  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    on_cnt_d  = on_cnt_q;
    period_d  = period_q;
    on_time_d = on_time_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    stuck_d   = stuck_q;
    case (state_q)
      SEEK: begin
        per_cnt_d = '0;
        on_cnt_d  = '0;
        if (rise) begin
          state_d   = RUN;
          per_cnt_d = CNT_ONE;
          on_cnt_d  = CNT_ONE;
        end
      end
      RUN: begin
        if (rise) begin
          period_d  = per_cnt_q;
          on_time_d = on_cnt_q;
          valid_d   = 1'b1;
          per_cnt_d = CNT_ONE;
          on_cnt_d  = CNT_ONE;
        end else if (!cnt_saturated(per_cnt_q)) begin
          per_cnt_d = per_cnt_q + CNT_ONE;
          on_cnt_d  = on_cnt_q + CW'(act);
        end else begin
          timeout_d = 1'b1;
          stuck_d   = act;
          per_cnt_d = '0;
          on_cnt_d  = '0;
          state_d   = SEEK;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      sync_q    <= SYNC_IDLE;
      act_dly_q <= 1'b0;
      state_q   <= SEEK;
      per_cnt_q <= '0;
      on_cnt_q  <= '0;
      period_q  <= '0;
      on_time_q <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      act_dly_q <= act_dly_d;
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      on_cnt_q  <= on_cnt_d;
      period_q  <= period_d;
      on_time_q <= on_time_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      stuck_q   <= stuck_d;
    end
  end

  assign Period     = period_q;
  assign OnTime     = on_time_q;
  assign Valid      = valid_q;
  assign Timeout    = timeout_q;
  assign StuckLevel = stuck_q;
  assign Busy       = (state_q == RUN);

endmodule

// File: tb/tb_pif_pwm_capture.sv
// Bench for pif_pwm_capture: directed waveforms plus a random line checked
// against a sample-history reference model, on three parameterisations.
module tb_pif_pwm_capture;

  localparam int LEN = 1600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm = 1'b1;

  logic [15:0] a1_per, a1_on, a0_per, a0_on;
  logic        a1_vld, a1_to, a1_stk, a1_busy;
  logic        a0_vld, a0_to, a0_stk, a0_busy;
  logic [7:0]  c8_per, c8_on;
  logic        c8_vld, c8_to, c8_stk, c8_busy;

  int n_vec = 0;
  int n_err = 0;

  bit pin_seq [LEN];
  bit e_vld   [2][LEN];
  bit e_to    [2][LEN];
  bit e_busy  [2][LEN];
  bit e_stk   [2][LEN];
  int e_per   [2][LEN];
  int e_on    [2][LEN];

  always #5 clk = ~clk;

  pif_pwm_capture #(.CW(16), .SYNC_STAGES(2), .ACTIVE_LOW(1)) u_a1 (
    .Clk(clk), .ResetN(rst_n), .PwmIn(pwm), .Period(a1_per), .OnTime(a1_on),
    .Valid(a1_vld), .Timeout(a1_to), .StuckLevel(a1_stk), .Busy(a1_busy));

  pif_pwm_capture #(.CW(16), .SYNC_STAGES(2), .ACTIVE_LOW(0)) u_a0 (
    .Clk(clk), .ResetN(rst_n), .PwmIn(pwm), .Period(a0_per), .OnTime(a0_on),
    .Valid(a0_vld), .Timeout(a0_to), .StuckLevel(a0_stk), .Busy(a0_busy));

  pif_pwm_capture #(.CW(8), .SYNC_STAGES(2), .ACTIVE_LOW(1)) u_c8 (
    .Clk(clk), .ResetN(rst_n), .PwmIn(pwm), .Period(c8_per), .OnTime(c8_on),
    .Valid(c8_vld), .Timeout(c8_to), .StuckLevel(c8_stk), .Busy(c8_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit lvl);
    rst_n = 1'b0;
    pwm   = lvl;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic bit pat16(input int k);
    return ((k % 16) < 10) ? 1'b0 : 1'b1;
  endfunction

  // Expected outputs after the edge that samples pin_seq[j] (j counted from the
  // first edge after reset). A rise is an active sample following an inactive
  // one (reset counts as inactive) and shows up two edges later.
  task automatic run_model(input int sel, input bit al, input int maxv);
    bit run, a, ap, stk;
    int p, per, on;
    run = 1'b0; stk = 1'b0; p = 0; per = 0; on = 0;
    for (int j = 0; j < 2; j++) begin
      e_vld[sel][j] = 1'b0; e_to[sel][j] = 1'b0; e_busy[sel][j] = 1'b0;
      e_stk[sel][j] = 1'b0; e_per[sel][j] = 0;   e_on[sel][j] = 0;
    end
    for (int i = 0; i + 2 < LEN; i++) begin
      a  = pin_seq[i] ^ al;
      ap = (i > 0) ? (pin_seq[i-1] ^ al) : 1'b0;
      e_vld[sel][i+2] = 1'b0;
      e_to[sel][i+2]  = 1'b0;
      if (a && !ap) begin
        if (run) begin
          per = i - p;
          on  = 0;
          for (int q = p; q < i; q++) on += int'(pin_seq[q] ^ al);
          e_vld[sel][i+2] = 1'b1;
        end
        run = 1'b1;
        p   = i;
      end else if (run && (i - p) == maxv) begin
        e_to[sel][i+2] = 1'b1;
        stk = a;
        run = 1'b0;
      end
      e_busy[sel][i+2] = run;
      e_stk[sel][i+2]  = stk;
      e_per[sel][i+2]  = per;
      e_on[sel][i+2]   = on;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pwm   = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({a1_per, a1_on, a1_vld, a1_to, a1_stk, a1_busy} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_a1: got %h want 0", {a1_per, a1_on, a1_vld, a1_to, a1_stk, a1_busy});
    end
    n_vec++;
    if ({a0_per, a0_on, a0_vld, a0_to, a0_stk, a0_busy} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_a0: got %h want 0", {a0_per, a0_on, a0_vld, a0_to, a0_stk, a0_busy});
    end
    n_vec++;
    if ({c8_per, c8_on, c8_vld, c8_to, c8_stk, c8_busy} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_c8: got %h want 0", {c8_per, c8_on, c8_vld, c8_to, c8_stk, c8_busy});
    end
    rst_n = 1'b1;
  endtask

  // 10 low / 6 high, active-low: first rise silent, then Valid every 16 clocks.
  task automatic test_steady();
    bit ev, eb;
    do_reset(1'b1);
    for (int k = 0; k <= 82; k++) begin
      pwm = pat16(k);
      tick();
      ev = (k >= 18) && ((k - 18) % 16 == 0);
      eb = (k >= 2);
      n_vec++;
      if (a1_vld !== ev || a1_busy !== eb) begin
        n_err++;
        $display("FAIL steady_strobe k=%0d: vld=%b busy=%b want vld=%b busy=%b", k, a1_vld, a1_busy, ev, eb);
      end
      if (ev) begin
        n_vec++;
        if (a1_per !== 16'd16 || a1_on !== 16'd10) begin
          n_err++;
          $display("FAIL steady_sample k=%0d: per=%0d on=%0d want 16/10", k, a1_per, a1_on);
        end
      end
    end
  endtask

  task automatic test_polarity();
    bit ev;
    do_reset(1'b1);
    for (int k = 0; k <= 76; k++) begin
      pwm = pat16(k);
      tick();
      ev = (k >= 28) && ((k - 28) % 16 == 0);
      n_vec++;
      if (a0_vld !== ev) begin
        n_err++;
        $display("FAIL polarity_strobe k=%0d: vld=%b want %b", k, a0_vld, ev);
      end
      if (ev) begin
        n_vec++;
        if (a0_per !== 16'd16 || a0_on !== 16'd6) begin
          n_err++;
          $display("FAIL polarity_sample k=%0d: per=%0d on=%0d want 16/6", k, a0_per, a0_on);
        end
      end
    end
    n_vec++;
    if (a1_per !== a0_per || (int'(a1_on) + int'(a0_on)) != 16) begin
      n_err++;
      $display("FAIL polarity_sum: per %0d/%0d on %0d+%0d want equal periods, sum 16",
               a1_per, a0_per, a1_on, a0_on);
    end
  endtask

  // Active-high, 19 high / 1 low: a one-clock gap must still give a rise.
  task automatic test_duty();
    bit ev;
    do_reset(1'b0);
    for (int k = 0; k <= 62; k++) begin
      pwm = (k % 20 == 19) ? 1'b0 : 1'b1;
      tick();
      ev = (k >= 22) && ((k - 22) % 20 == 0);
      n_vec++;
      if (a0_vld !== ev) begin
        n_err++;
        $display("FAIL duty_strobe k=%0d: vld=%b want %b", k, a0_vld, ev);
      end
      if (ev) begin
        n_vec++;
        if (a0_per !== 16'd20 || a0_on !== 16'd19) begin
          n_err++;
          $display("FAIL duty_sample k=%0d: per=%0d on=%0d want 20/19", k, a0_per, a0_on);
        end
      end
    end
  endtask

  task automatic test_stuck();
    bit ev, et, eb;
    do_reset(1'b1);
    for (int k = 0; k <= 276; k++) begin
      if (k <= 257)      pwm = 1'b0;
      else if (k <= 261) pwm = 1'b1;
      else if (k <= 269) pwm = 1'b0;
      else if (k <= 273) pwm = 1'b1;
      else               pwm = 1'b0;
      tick();
      ev = (k == 276);
      et = (k == 257);
      eb = (k >= 2 && k <= 256) || (k >= 264);
      n_vec++;
      if (c8_vld !== ev || c8_to !== et || c8_busy !== eb) begin
        n_err++;
        $display("FAIL stuck_strobe k=%0d: vld=%b to=%b busy=%b want %b %b %b",
                 k, c8_vld, c8_to, c8_busy, ev, et, eb);
      end
      if (k == 257 || k == 276) begin
        n_vec++;
        if (c8_stk !== 1'b1) begin
          n_err++;
          $display("FAIL stuck_level k=%0d: got %b want 1", k, c8_stk);
        end
      end
      if (ev) begin
        n_vec++;
        if (c8_per !== 8'd12 || c8_on !== 8'd8) begin
          n_err++;
          $display("FAIL stuck_resume: per=%0d on=%0d want 12/8", c8_per, c8_on);
        end
      end
    end
  endtask

  task automatic test_sat_tie();
    bit ev;
    do_reset(1'b1);
    for (int k = 0; k <= 512; k++) begin
      pwm = (k % 255 == 0) ? 1'b0 : 1'b1;
      tick();
      ev = (k == 257) || (k == 512);
      n_vec++;
      if (c8_vld !== ev || c8_to !== 1'b0) begin
        n_err++;
        $display("FAIL sat_tie_strobe k=%0d: vld=%b to=%b want %b 0", k, c8_vld, c8_to, ev);
      end
      if (ev) begin
        n_vec++;
        if (c8_per !== 8'd255 || c8_on !== 8'd1 || c8_busy !== 1'b1) begin
          n_err++;
          $display("FAIL sat_tie_sample k=%0d: per=%0d on=%0d busy=%b want 255/1/1",
                   k, c8_per, c8_on, c8_busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ev;
    do_reset(1'b1);
    for (int k = 0; k <= 27; k++) begin
      pwm = pat16(k);
      tick();
      ev = (k == 18);
      n_vec++;
      if (a1_vld !== ev) begin
        n_err++;
        $display("FAIL midrst_pre k=%0d: vld=%b want %b", k, a1_vld, ev);
      end
    end
    rst_n = 1'b0;
    pwm   = pat16(28);
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({a1_per, a1_on, a1_vld, a1_to, a1_stk, a1_busy} !== 36'd0) begin
      n_err++;
      $display("FAIL midrst_clear: got %h want 0", {a1_per, a1_on, a1_vld, a1_to, a1_stk, a1_busy});
    end
    for (int m = 0; m <= 21; m++) begin
      pwm = pat16(29 + m);
      tick();
      ev = (m == 21);
      n_vec++;
      if (a1_vld !== ev || a1_busy !== (m >= 5)) begin
        n_err++;
        $display("FAIL midrst_post m=%0d: vld=%b busy=%b want %b %b", m, a1_vld, a1_busy, ev, (m >= 5));
      end
      if (ev) begin
        n_vec++;
        if (a1_per !== 16'd16 || a1_on !== 16'd10) begin
          n_err++;
          $display("FAIL midrst_sample: per=%0d on=%0d want 16/10", a1_per, a1_on);
        end
      end
    end
  endtask

  task automatic test_random();
    int idx, len;
    bit lvl;
    idx = 0;
    lvl = 1'($urandom_range(0, 1));
    while (idx < LEN) begin
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(230, 280)) : int'($urandom_range(1, 12));
      for (int q = 0; q < len && idx < LEN; q++) begin
        pin_seq[idx] = lvl;
        idx++;
      end
      lvl = ~lvl;
    end
    run_model(0, 1'b1, 255);
    run_model(1, 1'b0, 65535);
    do_reset(1'($urandom_range(0, 1)));
    for (int k = 0; k < LEN; k++) begin
      pwm = pin_seq[k];
      tick();
      n_vec++;
      if ({c8_vld, c8_to, c8_busy, c8_stk} !== {e_vld[0][k], e_to[0][k], e_busy[0][k], e_stk[0][k]} ||
          c8_per !== e_per[0][k][7:0] || c8_on !== e_on[0][k][7:0]) begin
        n_err++;
        $display("FAIL random_c8 k=%0d: vld/to/busy/stk=%b%b%b%b per=%0d on=%0d want %b%b%b%b per=%0d on=%0d",
                 k, c8_vld, c8_to, c8_busy, c8_stk, c8_per, c8_on,
                 e_vld[0][k], e_to[0][k], e_busy[0][k], e_stk[0][k], e_per[0][k], e_on[0][k]);
      end
      n_vec++;
      if ({a0_vld, a0_to, a0_busy, a0_stk} !== {e_vld[1][k], e_to[1][k], e_busy[1][k], e_stk[1][k]} ||
          a0_per !== e_per[1][k][15:0] || a0_on !== e_on[1][k][15:0]) begin
        n_err++;
        $display("FAIL random_a0 k=%0d: vld/to/busy/stk=%b%b%b%b per=%0d on=%0d want %b%b%b%b per=%0d on=%0d",
                 k, a0_vld, a0_to, a0_busy, a0_stk, a0_per, a0_on,
                 e_vld[1][k], e_to[1][k], e_busy[1][k], e_stk[1][k], e_per[1][k], e_on[1][k]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_steady();
    test_polarity();
    test_duty();
    test_stuck();
    test_sat_tie();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
